// File: rtl/seq_stage_controller_pkg.sv
// Shared definitions for the SEQ stage sequencer: icodes, status codes, state encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seq_stage_controller_pkg;

    // Y86-64 instruction codes
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPDATE  = 3'd6,
        S_HALTED    = 3'd7
    } state_t;

    // Instructions that touch data memory
    function automatic logic uses_mem(input logic [3:0] ic);
        case (ic)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
            ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Instructions that write the register file (rmmovq is the only memory op that does not)
    function automatic logic uses_wb(input logic [3:0] ic);
        case (ic)
            ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_OPQ, ICODE_MRMOVQ,
            ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_stage_controller_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
// Latency: count updates one cycle after en.
// Backpressure: none; en is a plain level.
module seq_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Increment while enabled unless already saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Moore sequencer stepping the SEQ datapath through one stage per cycle, with status and counters.
// Latency: 4..6 cycles per instruction plus any data-memory wait cycles.
// Backpressure: stalls in MEMORY until mem_ready, bounded by MEM_TIMEOUT (then ADR halt).
module seq_stage_controller
    import seq_stage_controller_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic             mem_req,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    logic [3:0]    icode_q;
    logic [TW-1:0] tcnt;
    logic          instr_inc;

    // Stage enables are a pure decode of the state register
    assign fetch_en     = (state == S_FETCH);
    assign decode_en    = (state == S_DECODE);
    assign execute_en   = (state == S_EXECUTE);
    assign memory_en    = (state == S_MEMORY);
    assign writeback_en = (state == S_WRITEBACK);
    assign pc_en        = (state == S_PCUPDATE);
    assign mem_req      = memory_en;
    assign halted       = (state == S_HALTED);
    assign busy         = (state != S_IDLE) && !halted;

    // A halt instruction retires at FETCH since it never reaches PCUPDATE
    assign instr_inc = pc_en ||
                       (fetch_en && !imem_error && (icode == ICODE_HALT));

    // Stage sequencing, status tracking and data-memory timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            stat    <= STAT_AOK;
            icode_q <= '0;
            tcnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    icode_q <= icode;
                    if (imem_error) begin
                        stat  <= STAT_ADR;
                        state <= S_HALTED;
                    end else if (icode > ICODE_POPQ) begin
                        stat  <= STAT_INS;
                        state <= S_HALTED;
                    end else if (icode == ICODE_HALT) begin
                        stat  <= STAT_HLT;
                        state <= S_HALTED;
                    end else begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    if (uses_mem(icode_q)) begin
                        tcnt  <= '0;
                        state <= S_MEMORY;
                    end else if (uses_wb(icode_q)) begin
                        state <= S_WRITEBACK;
                    end else begin
                        state <= S_PCUPDATE;
                    end
                end
                S_MEMORY: begin
                    // A late mem_ready on the final allowed cycle still completes normally
                    if (mem_ready) begin
                        if (dmem_error) begin
                            stat  <= STAT_ADR;
                            state <= S_HALTED;
                        end else if (uses_wb(icode_q)) begin
                            state <= S_WRITEBACK;
                        end else begin
                            state <= S_PCUPDATE;
                        end
                    end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
                        stat  <= STAT_ADR;
                        state <= S_HALTED;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WRITEBACK: state <= S_PCUPDATE;
                S_PCUPDATE: state <= run ? S_FETCH : S_IDLE;
                S_HALTED: begin
                    if (clear) begin
                        stat  <= STAT_AOK;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    seq_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .count (cycle_count)
    );

    seq_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (instr_inc),
        .count (instr_count)
    );

endmodule
